// File: rtl/gen_reg.sv
// Six-entry, 20-bit register file with one combined write/read port.
// Each access targets the full word, the high half [19:10] or the low half [9:0].
module gen_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr_sel,
    input  logic [9:0]  addr,
    input  logic [19:0] data_in,
    output logic [19:0] data_out
);

    typedef enum logic [1:0] {
        MODE_FULL = 2'b00,
        MODE_HIGH = 2'b01,
        MODE_LOW  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam int NUM_REGS = 6;

    mode_e       mode;
    logic [19:0] regs_q [NUM_REGS];
    logic [19:0] regs_d [NUM_REGS];
    logic [19:0] rd_word;

    assign mode = mode_e'(addr_sel);

    // The full 10-bit address is compared, so indices 6..1023 never alias R0..R5.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (addr == 10'(i)) begin
                case (mode)
                    MODE_FULL: regs_d[i] = data_in;
                    MODE_HIGH: regs_d[i] = {data_in[19:10], regs_q[i][9:0]};
                    MODE_LOW:  regs_d[i] = {regs_q[i][19:10], data_in[9:0]};
                    default:   regs_d[i] = regs_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read path: no write-through, so data_out shows stored contents only.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 10'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        data_out = rd_word;
        case (mode)
            MODE_HIGH: data_out = {rd_word[19:10], 10'h000};
            MODE_LOW:  data_out = {10'h000, rd_word[9:0]};
            default:   data_out = rd_word;
        endcase
    end

endmodule

// File: tb/tb_gen_reg.sv
// Directed bench for gen_reg: half/full writes, hold mode, out-of-range
// addresses and asynchronous reset, checked with immediate assertions.
module tb_gen_reg;

    logic        clk;
    logic        rst;
    logic [1:0]  addr_sel;
    logic [9:0]  addr;
    logic [19:0] data_in;
    logic [19:0] data_out;

    int n_compared;
    int n_mismatched;

    logic [19:0] exp_regs [6];

    gen_reg dut (
        .clk      (clk),
        .rst      (rst),
        .addr_sel (addr_sel),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [9:0] a, input logic [1:0] s, input logic [19:0] d);
        addr     = a;
        addr_sel = s;
        data_in  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s: observed %05h expected %05h", tag, observed, expected);
        end
    endtask

    // Reads every register in hold mode and compares with the bench's own copy.
    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 6; i++) begin
            drive(10'(i), 2'b11, 20'h00000);
            #1;
            check($sformatf("%s_r%0d", tag, i), data_out, exp_regs[i]);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        for (int i = 0; i < 6; i++) exp_regs[i] = 20'h00000;

        // Reset state in every read mode
        rst = 1'b1;
        drive(10'd0, 2'b11, 20'h00000);
        repeat (2) @(negedge clk);
        drive(10'd0, 2'b00, 20'hFFFFF);
        #1 check("rst_full", data_out, 20'h00000);
        drive(10'd3, 2'b01, 20'hFFFFF);
        #1 check("rst_high", data_out, 20'h00000);
        drive(10'd5, 2'b10, 20'hFFFFF);
        #1 check("rst_low", data_out, 20'h00000);
        @(negedge clk);
        drive(10'd0, 2'b11, 20'h00000);
        rst = 1'b0;

        // Full word write
        drive(10'd0, 2'b00, 20'hAAAAA);
        step();
        check("full_dout", data_out, 20'hAAAAA);
        exp_regs[0] = 20'hAAAAA;
        drive(10'd0, 2'b11, 20'h00000);
        #1 check("full_r0", data_out, 20'hAAAAA);

        // High half write
        drive(10'd1, 2'b01, 20'hCCCCC);
        step();
        check("high_dout", data_out, 20'hCCC00);
        exp_regs[1] = 20'hCCC00;
        drive(10'd1, 2'b11, 20'h00000);
        #1 check("high_r1", data_out, 20'hCCC00);

        // Low half write
        drive(10'd2, 2'b10, 20'hF0F0F);
        step();
        check("low_dout", data_out, 20'h0030F);
        exp_regs[2] = 20'h0030F;
        drive(10'd2, 2'b11, 20'h00000);
        #1 check("low_r2", data_out, 20'h0030F);

        // Merge full then high half, then hold for three edges
        drive(10'd3, 2'b00, 20'h12345);
        step();
        check("merge_full", data_out, 20'h12345);
        drive(10'd3, 2'b01, 20'hFFFFF);
        step();
        drive(10'd3, 2'b00, 20'hFFFFF);
        #1 check("merge_r3_full_view", data_out, 20'hFFF45);
        drive(10'd3, 2'b10, 20'hFFFFF);
        #1 check("merge_r3_low_view", data_out, 20'h00345);
        exp_regs[3] = 20'hFFF45;
        drive(10'd3, 2'b11, 20'h00000);
        for (int e = 0; e < 3; e++) begin
            step();
            check($sformatf("hold_edge%0d", e), data_out, 20'hFFF45);
        end

        // No write-through: old value visible before the edge
        drive(10'd4, 2'b00, 20'hABCDE);
        #1 check("nobypass_before", data_out, 20'h00000);
        step();
        check("nobypass_after", data_out, 20'hABCDE);
        exp_regs[4] = 20'hABCDE;

        // Out-of-range addresses in each writing mode
        drive(10'd6, 2'b00, 20'h55555);
        #1 check("oor6_before", data_out, 20'h00000);
        step();
        check("oor6_dout", data_out, 20'h00000);
        drive(10'd1023, 2'b00, 20'h55555);
        step();
        check("oor1023_dout", data_out, 20'h00000);
        drive(10'd7, 2'b01, 20'h55555);
        step();
        check("oor7_dout", data_out, 20'h00000);
        drive(10'd64, 2'b10, 20'h55555);
        step();
        check("oor64_dout", data_out, 20'h00000);
        check_all_regs("oor");

        // Load all registers with nonzero values
        for (int i = 0; i < 6; i++) begin
            drive(10'(i), 2'b00, 20'h11111 * 20'(i + 1));
            step();
            exp_regs[i] = 20'h11111 * 20'(i + 1);
        end
        check_all_regs("load");

        // Async reset between edges, with a write pending on the same edge
        step();
        drive(10'd5, 2'b00, 20'h77777);
        #1 check("pre_rst_r5", data_out, 20'h66666);
        #1 rst = 1'b1;
        #1 check("rst_async_dout", data_out, 20'h00000);
        step();
        check("rst_edge_dout", data_out, 20'h00000);
        for (int i = 0; i < 6; i++) exp_regs[i] = 20'h00000;
        drive(10'd0, 2'b11, 20'h00000);
        #1 rst = 1'b0;
        check_all_regs("post_rst");

        // First edge after reset release performs a normal write
        drive(10'd2, 2'b00, 20'h13579);
        step();
        check("post_rst_write", data_out, 20'h13579);
        drive(10'd2, 2'b01, 20'h00000);
        #1 check("post_rst_high_view", data_out, 20'h13400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
